dmem_bytelane: RTL and testbench
================================

Name: dmem_bytelane

Overview:
- Parametrised single-clock data memory for the CPU load/store path. Successor to the current dual-clock, word-only data RAM.
- Accepts byte/half/word (and dword when DATA_W=64) loads and stores with automatic lane steering and sign/zero extension.
- Adds misalignment detection, a post-reset clear sequencer and a valid/ready handshake.
- Sits between the LSU and on-chip RAM.

Parameters:
- DATA_W, 32, word width in bits; 32 or 64 only; NB = DATA_W/8 byte lanes.
- ADDR_W, 17, byte-address width; DEPTH = 2^(ADDR_W-log2(NB)) words.
- CLEAR_ON_RESET, 1, 1 = zero every word after reset; 0 = skip clear, contents undefined (or preloaded by the synthesis tool).

Ports:
- clock  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  byte address
- req_size  in  2  00 byte, 01 half, 10 word, 11 dword (legal only when DATA_W=64)
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_wdata  in  DATA_W  store data, right-justified
- rsp_valid  out  1  response valid, one cycle after acceptance
- rsp_rdata  out  DATA_W  extended load data; 0 for stores and errors
- rsp_err  out  2  00 ok, 01 misaligned/illegal size, 10 parity error

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. Ports are named clock and reset.
- Outputs at reset: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=00.
- FSM states: CLEAR, RUN.
  - Reset enters CLEAR when CLEAR_ON_RESET=1, otherwise RUN.
  - CLEAR: counter clr_idx starts at 0 and writes all-zero (with even parity) to word clr_idx each cycle.
  - CLEAR to RUN transition happens after word DEPTH-1 is written; a full clear takes exactly DEPTH cycles. req_ready=0 throughout CLEAR.
  - Reset asserted mid-clear restarts clr_idx at 0.
- RUN: req_ready=1 every cycle; no back-pressure. Accept = req_valid & req_ready.
- Alignment check: request is misaligned if req_addr mod 2^req_size != 0.
  - Size 11 with DATA_W=32 is illegal.
  - Misaligned or illegal requests perform no write and return rsp_err=01, rdata=0.
- Store:
  - Byte-enable mask = (2^(2^size)-1) << (addr mod NB).
  - Write data = req_wdata replicated into the addressed lanes.
  - Enabled lanes are written on the acceptance edge; other lanes are unchanged. No read-modify-write.
- Load:
  - Synchronous RAM read on the acceptance edge.
  - The next cycle shifts the selected lanes down and sign/zero-extends to DATA_W.
- Latency: rsp_valid asserts exactly 1 cycle after acceptance, for 1 cycle. Full throughput: back-to-back requests give back-to-back responses.
- Store then load to the same word on consecutive cycles returns the new data; the write lands before the next read edge.
- Word index = req_addr[ADDR_W-1:log2(NB)]; the address space wraps naturally, so no out-of-range case exists.
- Reset asserted while a response is pending drops it: rsp_valid=0 on the following cycle.

Optional Feature:
- DMEM_PARITY_EN defined:
  - RAM stores one even-parity bit per byte lane, written with every store and during CLEAR.
  - Loads check parity on the accessed lanes only. Any mismatch returns rsp_err=10, with rsp_rdata still driven with the extended data.
  - Misalignment takes priority over parity.
- DMEM_PARITY_EN undefined: no parity storage; rsp_err is never 10.

Decomposition:
- Package dmem_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_DWORD
  - error codes ERR_OK/ERR_ALIGN/ERR_PARITY
  - FSM state typedef (CLEAR, RUN)
  - mask/extension helper functions
- One sub-module: dmem_ram, a byte-enabled synchronous single-port RAM parametrised by NB, depth and lane width (8 or 9 bits).
- Lane steering, FSM and error logic stay in the top.

Test Plan:
- Reset with CLEAR_ON_RESET=1, DEPTH=16 -> req_ready low for exactly 16 cycles, then high; a word load at addr 0x3C returns 0.
- sw 0x80FF7F01 @0x10; then lb @0x10, lb @0x11, lbu @0x12, lh @0x12, lhu @0x12 -> 0x00000001, 0x0000007F, 0x000000FF, 0xFFFF80FF, 0x000080FF, each rsp_valid one cycle after its request.
- sb 0xAA @0x21 on a word holding 0x11223344 @0x20, then lw @0x20 on the next cycle -> 0x1122AA44.
- lh @0x03 and sw @0x06 -> rsp_err=01, rdata=0; a subsequent lw @0x04 shows memory unchanged.
- Reset asserted for 1 cycle while an lw response is pending and mid-CLEAR -> no rsp_valid; clear restarts, and req_ready stays low for a full DEPTH cycles.
- With DMEM_PARITY_EN: force a flipped bit in lane 1 of word 0x20 -> lbu @0x21 returns rsp_err=10; lbu @0x20 returns rsp_err=00.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings and helpers for dmem_bytelane
package dmem_pkg;

  // Access size encodings on req_size
  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [1:0] SZ_DWORD = 2'b11;

  // Response error codes on rsp_err
  localparam logic [1:0] ERR_OK     = 2'b00;
  localparam logic [1:0] ERR_ALIGN  = 2'b01;
  localparam logic [1:0] ERR_PARITY = 2'b10;

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  // Unshifted lane mask for an access size (one bit per byte)
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    logic [7:0] m;
    case (size)
      SZ_BYTE: m = 8'h01;
      SZ_HALF: m = 8'h03;
      SZ_WORD: m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  // Misaligned, or a dword on a 4-lane memory
  function automatic logic misaligned(input logic [2:0] lo, input logic [1:0] size,
                                      input int nb);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lo[0];
      SZ_WORD: bad = |lo[1:0];
      default: bad = (nb < 8) || (|lo);
    endcase
    return bad;
  endfunction

  // Sign/zero extension of right-justified load data
  function automatic logic [63:0] extend_load(input logic [63:0] d, input logic [1:0] size,
                                              input logic uns);
    logic [63:0] r;
    case (size)
      SZ_BYTE: r = uns ? {56'b0, d[7:0]}  : {{56{d[7]}}, d[7:0]};
      SZ_HALF: r = uns ? {48'b0, d[15:0]} : {{48{d[15]}}, d[15:0]};
      SZ_WORD: r = uns ? {32'b0, d[31:0]} : {{32{d[31]}}, d[31:0]};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// rtl/dmem_ram.sv - byte-enabled synchronous single-port RAM
module dmem_ram #(
  parameter int NB     = 4,
  parameter int DEPTH  = 16,
  parameter int LANE_W = 8,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                 clock,
  input  logic                 we,
  input  logic [NB-1:0]        be,
  input  logic [AW-1:0]        addr,
  input  logic [NB*LANE_W-1:0] wdata,
  output logic [NB*LANE_W-1:0] rdata
);

  logic [LANE_W-1:0] mem [DEPTH][NB];

  // Per-lane write and registered read of the addressed word
  always_ff @(posedge clock) begin
    for (int i = 0; i < NB; i++) begin
      if (we && be[i]) mem[addr][i] <= wdata[i*LANE_W +: LANE_W];
      rdata[i*LANE_W +: LANE_W] <= mem[addr][i];
    end
  end

endmodule

// File: rtl/dmem_bytelane.sv
// rtl/dmem_bytelane.sv - byte-lane data memory with clear sequencer; DMEM_PARITY_EN adds lane parity
module dmem_bytelane
  import dmem_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 17,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_err
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int WA_W  = ADDR_W - OFF_W;
  localparam int DEPTH = 1 << WA_W;
`ifdef DMEM_PARITY_EN
  localparam int LANE_W = 9;
`else
  localparam int LANE_W = 8;
`endif

  state_t              state, state_nxt;
  logic [WA_W-1:0]     clr_idx, clr_idx_nxt;
  logic                clr_we;
  logic                accept, mis;
  logic [OFF_W-1:0]    req_off;
  logic [NB-1:0]       req_be;
  logic [63:0]         wd64;
  logic [NB*LANE_W-1:0] st_data;
  logic                ram_we;
  logic [NB-1:0]       ram_be;
  logic [WA_W-1:0]     ram_addr;
  logic [NB*LANE_W-1:0] ram_wdata, ram_rdata;

  logic                pend_load, pend_mis, pend_uns;
  logic [1:0]          pend_size;
  logic [OFF_W-1:0]    pend_off;
  logic [63:0]         rd_bytes;
  logic                par_bad;
`ifdef DMEM_PARITY_EN
  logic [NB-1:0]       pend_be;
`endif

  // State register; reset restarts the clear from word 0
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      clr_idx <= '0;
    end else begin
      state   <= state_nxt;
      clr_idx <= clr_idx_nxt;
    end
  end

  // Clear sequencing and ready generation; ready held low while in reset
  always_comb begin
    state_nxt   = state;
    clr_idx_nxt = clr_idx;
    clr_we      = 1'b0;
    req_ready   = 1'b0;
    case (state)
      ST_CLEAR: begin
        clr_we      = 1'b1;
        clr_idx_nxt = clr_idx + 1'b1;
        if (clr_idx == WA_W'(DEPTH - 1)) state_nxt = ST_RUN;
      end
      default: req_ready = ~reset;
    endcase
  end

  assign accept  = req_valid & req_ready;
  assign req_off = req_addr[OFF_W-1:0];
  assign mis     = misaligned(req_addr[2:0], req_size, NB);
  assign req_be  = NB'(size_mask(req_size) << req_off);
  assign wd64    = 64'(req_wdata);

  // Replicate the store bytes across the lanes so each enabled lane sees its byte
  always_comb begin
    logic [2:0] src;
    logic [7:0] sbyte;
    st_data = '0;
    src     = '0;
    sbyte   = '0;
    for (int i = 0; i < NB; i++) begin
      src   = 3'(i) & 3'((4'd1 << req_size) - 4'd1);
      sbyte = wd64[{src, 3'b000} +: 8];
`ifdef DMEM_PARITY_EN
      st_data[i*LANE_W +: LANE_W] = {^sbyte, sbyte};
`else
      st_data[i*LANE_W +: LANE_W] = sbyte;
`endif
    end
  end

  assign ram_we    = clr_we | (accept & req_we & ~mis);
  assign ram_be    = clr_we ? '1 : req_be;
  assign ram_addr  = clr_we ? clr_idx : req_addr[ADDR_W-1:OFF_W];
  assign ram_wdata = clr_we ? '0 : st_data;

  dmem_ram #(
    .NB     (NB),
    .DEPTH  (DEPTH),
    .LANE_W (LANE_W),
    .AW     (WA_W)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .be    (ram_be),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Response pipeline: remembers what the RAM read returns for next cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      pend_load <= 1'b0;
      pend_mis  <= 1'b0;
      pend_uns  <= 1'b0;
      pend_size <= '0;
      pend_off  <= '0;
    end else begin
      rsp_valid <= accept;
      pend_load <= accept & ~req_we & ~mis;
      pend_mis  <= accept & mis;
      pend_uns  <= req_unsigned;
      pend_size <= req_size;
      pend_off  <= req_off;
    end
  end

`ifdef DMEM_PARITY_EN
  // Lanes whose parity is checked on the pending load
  always_ff @(posedge clock) begin
    if (reset) pend_be <= '0;
    else       pend_be <= req_be;
  end
`endif

  // Strip parity from the read word and flag bad parity on accessed lanes
  always_comb begin
    rd_bytes = '0;
    par_bad  = 1'b0;
    for (int i = 0; i < NB; i++) begin
      rd_bytes[i*8 +: 8] = ram_rdata[i*LANE_W +: 8];
`ifdef DMEM_PARITY_EN
      if (pend_be[i] && (^ram_rdata[i*LANE_W +: LANE_W])) par_bad = 1'b1;
`endif
    end
  end

  // Shift the addressed lanes down, extend, and select the error code
  always_comb begin
    rsp_rdata = '0;
    rsp_err   = ERR_OK;
    if (pend_load)
      rsp_rdata = DATA_W'(extend_load(rd_bytes >> {pend_off, 3'b000}, pend_size, pend_uns));
    if (pend_mis)                  rsp_err = ERR_ALIGN;
    else if (pend_load && par_bad) rsp_err = ERR_PARITY;
  end

endmodule

// File: tb/tb_dmem_bytelane.sv
// tb/tb_dmem_bytelane.sv - randomized self-checking bench against a byte-array memory model
module tb_dmem_bytelane;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [5:0]  req_addr = '0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] mem_m [64];

  dmem_bytelane #(
    .DATA_W         (32),
    .ADDR_W         (6),
    .CLEAR_ON_RESET (1)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input int addr, input int size, input bit uns);
    int n;
    logic [31:0] v;
    n = 1 << size;
    v = '0;
    for (int k = 0; k < n; k++) v = v | (32'(mem_m[addr + k]) << (8 * k));
    if (!uns && n < 4 && v[8 * n - 1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 64; i++) mem_m[i] = 8'h00;
  endtask

  // One request; response checked one cycle later; leaves req_valid high for back-to-back use
  task automatic issue(input bit we, input int addr, input int size, input bit uns,
                       input logic [31:0] wd);
    bit mis;
    logic [31:0] exp_d;
    mis   = (size == 3) || ((addr % (1 << size)) != 0);
    exp_d = '0;
    if (!mis && !we) exp_d = model_load(addr, size, uns);
    if (!mis && we)
      for (int k = 0; k < (1 << size); k++) mem_m[addr + k] = wd[8 * k +: 8];
    req_valid = 1'b1; req_we = we; req_addr = 6'(addr); req_size = 2'(size);
    req_unsigned = uns; req_wdata = wd;
    @(posedge clock); #1;
    check("rsp_valid", rsp_valid, 1);
    check("rsp_rdata", rsp_rdata, exp_d);
    check("rsp_err", rsp_err, mis ? 2'b01 : 2'b00);
  endtask

  task automatic idle();
    req_valid = 1'b0;
    @(posedge clock); #1;
    check("rsp_idle", rsp_valid, 0);
  endtask

  // Count cycles with req_ready low; bounded
  task automatic count_clear(input string tag);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    check(tag, n, 16);
  endtask

  initial begin
    model_clear();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("reset_ready", req_ready, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rdata", rsp_rdata, 0);
    check("reset_err", rsp_err, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    count_clear("clear_cycles");

    issue(0, 'h3C, 2, 0, 0);
    issue(1, 'h10, 2, 0, 32'h80FF7F01);
    issue(0, 'h10, 0, 0, 0);
    issue(0, 'h11, 0, 0, 0);
    issue(0, 'h12, 0, 1, 0);
    issue(0, 'h12, 1, 0, 0);
    issue(0, 'h12, 1, 1, 0);
    issue(1, 'h20, 2, 0, 32'h11223344);
    issue(1, 'h21, 0, 0, 32'h000000AA);
    issue(0, 'h20, 2, 0, 0);
    issue(1, 'h04, 2, 0, 32'hCAFEF00D);
    issue(0, 'h03, 1, 0, 0);
    issue(1, 'h06, 2, 0, 32'h12345678);
    issue(0, 'h04, 2, 0, 0);
    issue(0, 'h04, 3, 0, 0);
    idle();

    for (int i = 0; i < 300; i++) begin
      issue($urandom_range(0, 1), $urandom_range(0, 63), $urandom_range(0, 3),
            $urandom_range(0, 1), $urandom);
      if ($urandom_range(0, 7) == 0) idle();
    end
    idle();

`ifdef DMEM_PARITY_EN
    issue(1, 'h20, 2, 0, 32'h11223344);
    idle();
    dut.u_ram.mem[8][1][0] = ~dut.u_ram.mem[8][1][0];
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b1;
    req_addr = 6'h21;
    @(posedge clock); #1;
    check("parity_bad_err", rsp_err, 2'b10);
    req_addr = 6'h20;
    @(posedge clock); #1;
    check("parity_ok_err", rsp_err, 2'b00);
    check("parity_ok_rdata", rsp_rdata, 32'h44);
    idle();
`endif

    req_valid = 1'b1; req_we = 1'b0; req_addr = 6'h10; req_size = 2'b10; reset = 1'b1;
    @(posedge clock); #1;
    check("reset_drop_rsp", rsp_valid, 0);
    req_valid = 1'b0; reset = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    check("mid_clear_ready", req_ready, 0);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    count_clear("reclear_cycles");
    model_clear();
    issue(0, 'h10, 2, 0, 0);
    issue(0, 'h20, 2, 0, 0);
    issue(0, 'h3C, 2, 0, 0);
    idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
